// File: rtl/pcap_stream_pkg.sv
// rtl/pcap_stream_pkg.sv - shared constants, state type and helpers for pcap stream stages
package pcap_stream_pkg;

  localparam int PCAP_REC_HDR_BYTES   = 16;
  localparam int PCAP_INCL_LEN_OFFSET = 8;
  localparam int KEEP_MAX             = 256;

  typedef enum logic [1:0] {HDR, BODY, FLUSH, DROP} hdr_strip_state_t;

  function automatic int cdiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Low n bits set, saturated at b; callers cast down to their tkeep width.
  function automatic logic [KEEP_MAX-1:0] keep_from_count(input int unsigned n, input int unsigned b);
    logic [KEEP_MAX-1:0] k;
    for (int unsigned i = 0; i < 32'(KEEP_MAX); i++) begin
      k[i] = (i < n) && (i < b);
    end
    return k;
  endfunction

endpackage

// File: rtl/axi4s_reg_slice.sv
// rtl/axi4s_reg_slice.sv - single-entry registered AXI4-Stream output stage with sideband
module axi4s_reg_slice #(
  parameter int AXI_WIDTH = 64,
  parameter int USER_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AXI_WIDTH-1:0]   s_tdata,
  input  logic [AXI_WIDTH/8-1:0] s_tkeep,
  input  logic                   s_tlast,
  input  logic [USER_W-1:0]      s_tuser,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [AXI_WIDTH-1:0]   m_tdata,
  output logic [AXI_WIDTH/8-1:0] m_tkeep,
  output logic                   m_tlast,
  output logic [USER_W-1:0]      m_tuser,
  output logic                   m_tvalid,
  input  logic                   m_tready
);

  logic [AXI_WIDTH-1:0]   r_data;
  logic [AXI_WIDTH/8-1:0] r_keep;
  logic                   r_last;
  logic [USER_W-1:0]      r_user;
  logic                   r_valid;

  assign s_tready = !r_valid || m_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_user  <= '0;
      r_valid <= 1'b0;
    end else if (s_tready) begin
      r_valid <= s_tvalid;
      if (s_tvalid) begin
        r_data <= s_tdata;
        r_keep <= s_tkeep;
        r_last <= s_tlast;
        r_user <= s_tuser;
      end
    end
  end

  assign m_tdata  = r_data;
  assign m_tkeep  = r_keep;
  assign m_tlast  = r_last;
  assign m_tuser  = r_user;
  assign m_tvalid = r_valid;

endmodule

// File: rtl/pcap_axi4s_hdr_strip.sv
// rtl/pcap_axi4s_hdr_strip.sv - strips pcap record header, realigns payload, derives tkeep/tlast from length
module pcap_axi4s_hdr_strip
  import pcap_stream_pkg::*;
#(
  parameter int AXI_WIDTH  = 64,
  parameter int HDR_BYTES  = PCAP_REC_HDR_BYTES,
  parameter int LEN_OFFSET = PCAP_INCL_LEN_OFFSET
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AXI_WIDTH-1:0]   in_tdata,
  input  logic                   in_tvalid,
  input  logic                   in_tlast,
  output logic                   in_tready,
  output logic [AXI_WIDTH-1:0]   out_tdata,
  output logic [AXI_WIDTH/8-1:0] out_tkeep,
  output logic                   out_tlast,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic [31:0]            out_len,
  output logic                   err_short,
  output logic                   err_long
);

  localparam int          B         = AXI_WIDTH / 8;
  localparam int          S         = HDR_BYTES % B;
  localparam int          HDR_BEATS = cdiv(HDR_BYTES, B);
  localparam int          RES_SH    = S * 8;
  localparam int          IN_SH     = (S == 0) ? 0 : (B - S) * 8;
  localparam logic [7:0]  LAST_HB   = 8'(HDR_BEATS - 1);
  localparam logic [31:0] B32       = 32'(B);
  localparam logic [31:0] RES32     = 32'(B - S);

  hdr_strip_state_t     r_state;
  logic                 r_live;
  logic [7:0]           r_hdr_beat;
  logic [31:0]          r_len_acc;
  logic [31:0]          r_len;
  logic [31:0]          r_rem;
  logic [AXI_WIDTH-1:0] r_res;
  logic                 r_saw_last;
  logic                 r_long_pend;
  logic                 r_err_short;
  logic                 r_err_long;

  logic                 w_s_ready;
  logic                 w_in_ready;
  logic                 w_acc;
  logic [31:0]          w_len_now;
  logic [AXI_WIDTH-1:0] w_word;
  logic [AXI_WIDTH-1:0] w_src;
  logic [AXI_WIDTH-1:0] w_data;
  logic [B-1:0]         w_keep;
  logic [31:0]          w_count;
  logic                 w_push;
  logic                 w_last;

  assign w_in_ready = r_live && ((r_state == HDR) || (r_state == DROP) ||
                                 ((r_state == BODY) && w_s_ready));
  assign w_acc      = in_tvalid && w_in_ready;
  assign in_tready  = w_in_ready;

  // Residue bytes sit low; the new beat's leading S bytes fill the top of the word.
  assign w_word = (S == 0) ? in_tdata : (r_res | (in_tdata << IN_SH));

  // Length bytes may straddle header beats; merge this beat's share into the accumulator.
  always_comb begin
    w_len_now = r_len_acc;
    for (int k = 0; k < 4; k++) begin
      if ((LEN_OFFSET + k) / B == int'(r_hdr_beat)) begin
        w_len_now[8*k +: 8] = in_tdata[8*((LEN_OFFSET + k) % B) +: 8];
      end
    end
  end

  always_comb begin
    w_push  = 1'b0;
    w_last  = 1'b0;
    w_count = '0;
    w_src   = w_word;
    if (r_state == BODY && w_acc) begin
      w_push = 1'b1;
      if (r_rem <= B32) begin
        w_count = r_rem;
        w_last  = 1'b1;
      end else begin
        w_count = B32;
        w_last  = (S == 0) && in_tlast;
      end
    end else if (r_state == FLUSH && w_s_ready) begin
      w_push  = 1'b1;
      w_src   = r_res;
      w_last  = 1'b1;
      w_count = (r_rem < RES32) ? r_rem : RES32;
    end
    w_keep = B'(keep_from_count(w_count, B));
    for (int i = 0; i < B; i++) begin
      w_data[8*i +: 8] = w_keep[i] ? w_src[8*i +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HDR;
      r_live      <= 1'b0;
      r_hdr_beat  <= '0;
      r_len_acc   <= '0;
      r_len       <= '0;
      r_rem       <= '0;
      r_res       <= '0;
      r_saw_last  <= 1'b0;
      r_long_pend <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      r_live      <= 1'b1;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      case (r_state)
        HDR: if (w_acc) begin
          if (r_hdr_beat == LAST_HB) begin
            r_hdr_beat  <= '0;
            r_len_acc   <= '0;
            r_len       <= w_len_now;
            r_rem       <= w_len_now;
            r_res       <= in_tdata >> RES_SH;
            r_saw_last  <= in_tlast;
            r_long_pend <= 1'b0;
            if (w_len_now == 32'd0) begin
              r_state <= in_tlast ? HDR : DROP;
            end else if (S == 0) begin
              if (in_tlast) r_err_short <= 1'b1;
              else          r_state     <= BODY;
            end else if (in_tlast || w_len_now <= RES32) begin
              r_state <= FLUSH;
            end else begin
              r_state <= BODY;
            end
          end else if (in_tlast) begin
            r_err_short <= 1'b1;
            r_hdr_beat  <= '0;
            r_len_acc   <= '0;
          end else begin
            r_hdr_beat <= r_hdr_beat + 8'd1;
            r_len_acc  <= w_len_now;
          end
        end
        BODY: if (w_acc) begin
          r_res      <= in_tdata >> RES_SH;
          r_saw_last <= in_tlast;
          if (r_rem <= B32) begin
            r_rem <= '0;
            if (in_tlast) begin
              r_state <= HDR;
            end else begin
              r_state     <= DROP;
              r_long_pend <= 1'b1;
            end
          end else begin
            r_rem <= r_rem - B32;
            if (S == 0) begin
              if (in_tlast) begin
                r_err_short <= 1'b1;
                r_state     <= HDR;
              end
            end else if (in_tlast || (r_rem - B32) <= RES32) begin
              r_state <= FLUSH;
            end
          end
        end
        FLUSH: if (w_s_ready) begin
          // More owed than the residue holds only happens after an early tlast.
          r_err_short <= (r_rem > RES32);
          r_rem       <= '0;
          if (r_saw_last) begin
            r_state <= HDR;
          end else begin
            r_state     <= DROP;
            r_long_pend <= 1'b1;
          end
        end
        DROP: if (w_acc) begin
          if (r_long_pend) begin
            r_err_long  <= 1'b1;
            r_long_pend <= 1'b0;
          end
          if (in_tlast) r_state <= HDR;
        end
        default: r_state <= HDR;
      endcase
    end
  end

  assign err_short = r_err_short;
  assign err_long  = r_err_long;

  axi4s_reg_slice #(
    .AXI_WIDTH (AXI_WIDTH),
    .USER_W    (32)
  ) u_out_slice (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (w_data),
    .s_tkeep  (w_keep),
    .s_tlast  (w_last),
    .s_tuser  (r_len),
    .s_tvalid (w_push),
    .s_tready (w_s_ready),
    .m_tdata  (out_tdata),
    .m_tkeep  (out_tkeep),
    .m_tlast  (out_tlast),
    .m_tuser  (out_len),
    .m_tvalid (out_tvalid),
    .m_tready (out_tready)
  );

endmodule

// File: tb/tb_pcap_axi4s_hdr_strip.sv
// tb/tb_pcap_axi4s_hdr_strip.sv - directed self-checking bench for pcap_axi4s_hdr_strip
module tb_pcap_axi4s_hdr_strip;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [31:0] len;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] d_tdata;
  logic        d_tvalid;
  logic        d_tlast;
  logic        sel;
  logic        out_tready = 1'b1;
  logic        toggle_en = 1'b0;
  logic [3:0]  rdy_pat = 4'b1001;
  int          rdy_idx = 0;
  logic        stall_chk = 1'b0;

  logic        in_tvalid_a, in_tready_a, out_tlast_a, out_tvalid_a, err_short_a, err_long_a;
  logic [63:0] out_tdata_a;
  logic [7:0]  out_tkeep_a;
  logic [31:0] out_len_a;
  logic        in_tvalid_b, in_tready_b, out_tlast_b, out_tvalid_b, err_short_b, err_long_b;
  logic [63:0] out_tdata_b;
  logic [7:0]  out_tkeep_b;
  logic [31:0] out_len_b;

  beat_t q_a[$];
  beat_t q_b[$];
  int    n_es_a = 0, n_el_a = 0, n_es_b = 0, n_el_b = 0;
  int    n_held = 0, n_viol = 0;
  int    n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  assign in_tvalid_a = d_tvalid && !sel;
  assign in_tvalid_b = d_tvalid && sel;

  pcap_axi4s_hdr_strip #(.AXI_WIDTH(64), .HDR_BYTES(16), .LEN_OFFSET(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_tdata(d_tdata), .in_tvalid(in_tvalid_a), .in_tlast(d_tlast), .in_tready(in_tready_a),
    .out_tdata(out_tdata_a), .out_tkeep(out_tkeep_a), .out_tlast(out_tlast_a),
    .out_tvalid(out_tvalid_a), .out_tready(out_tready), .out_len(out_len_a),
    .err_short(err_short_a), .err_long(err_long_a)
  );

  pcap_axi4s_hdr_strip #(.AXI_WIDTH(64), .HDR_BYTES(14), .LEN_OFFSET(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_tdata(d_tdata), .in_tvalid(in_tvalid_b), .in_tlast(d_tlast), .in_tready(in_tready_b),
    .out_tdata(out_tdata_b), .out_tkeep(out_tkeep_b), .out_tlast(out_tlast_b),
    .out_tvalid(out_tvalid_b), .out_tready(out_tready), .out_len(out_len_b),
    .err_short(err_short_b), .err_long(err_long_b)
  );

  always @(posedge clk) begin
    #1;
    if (toggle_en) begin
      out_tready = rdy_pat[rdy_idx];
      rdy_idx    = (rdy_idx + 1) % 4;
    end else begin
      out_tready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (out_tvalid_a && out_tready) q_a.push_back('{out_tdata_a, out_tkeep_a, out_tlast_a, out_len_a});
    if (out_tvalid_b && out_tready) q_b.push_back('{out_tdata_b, out_tkeep_b, out_tlast_b, out_len_b});
    if (err_short_a) n_es_a++;
    if (err_long_a)  n_el_a++;
    if (err_short_b) n_es_b++;
    if (err_long_b)  n_el_b++;
    if (stall_chk && out_tvalid_a && !out_tready) begin
      n_held++;
      if (!out_tlast_a && in_tready_a) n_viol++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    q_a.delete();
    q_b.delete();
    n_es_a = 0; n_el_a = 0; n_es_b = 0; n_el_b = 0;
  endtask

  task automatic send_beat(input logic [63:0] data, input logic last);
    int   t;
    logic ok;
    t  = 0;
    ok = 1'b0;
    d_tdata  = data;
    d_tvalid = 1'b1;
    d_tlast  = last;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = sel ? in_tready_b : in_tready_a;
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) check("send_timeout", {63'd0, ok}, 64'd1);
    d_tvalid = 1'b0;
    d_tlast  = 1'b0;
  endtask

  // Header bytes are 0xA0+i with the little-endian length at offset 8; payload byte i is i.
  task automatic send_pkt(input logic s, input int hdr, input logic [31:0] len,
                          input int npay, input int extra, input int max_beats);
    logic [7:0]  b [0:255];
    logic [63:0] w;
    int          nb;
    for (int i = 0; i < 256; i++) b[i] = 8'h00;
    for (int i = 0; i < hdr; i++) b[i] = 8'(8'hA0 + i);
    for (int k = 0; k < 4; k++) b[8 + k] = len[8*k +: 8];
    for (int i = 0; i < npay; i++) b[hdr + i] = 8'(i);
    nb  = (hdr + npay + 7) / 8 + extra;
    sel = s;
    for (int bi = 0; bi < nb && bi < max_beats; bi++) begin
      for (int j = 0; j < 8; j++) w[8*j +: 8] = b[bi*8 + j];
      send_beat(w, bi == nb - 1);
    end
  endtask

  task automatic chk_beat(input string tag, input logic s, input int idx, input logic [63:0] data,
                          input logic [7:0] keep, input logic last, input logic [31:0] len);
    beat_t bt;
    int    sz;
    sz = s ? q_b.size() : q_a.size();
    check({tag, "_present"}, {63'd0, idx < sz}, 64'd1);
    if (idx >= sz) return;
    bt = s ? q_b[idx] : q_a[idx];
    check({tag, "_data"}, bt.data, data);
    check({tag, "_keep"}, {56'd0, bt.keep}, {56'd0, keep});
    check({tag, "_last"}, {63'd0, bt.last}, {63'd0, last});
    check({tag, "_len"},  {32'd0, bt.len}, {32'd0, len});
  endtask

  initial begin
    rst_n    = 1'b0;
    d_tdata  = '0;
    d_tvalid = 1'b0;
    d_tlast  = 1'b0;
    sel      = 1'b0;
    drain(3);
    check("rst_out_tvalid", {63'd0, out_tvalid_a}, 64'd0);
    check("rst_out_tkeep",  {56'd0, out_tkeep_a}, 64'd0);
    check("rst_out_tdata",  out_tdata_a, 64'd0);
    check("rst_out_len",    {32'd0, out_len_a}, 64'd0);
    check("rst_errs",       {62'd0, err_short_a, err_long_a}, 64'd0);
    check("rst_in_tready",  {63'd0, in_tready_a}, 64'd0);
    rst_n = 1'b1;
    check("rel_in_tready_pre", {63'd0, in_tready_a}, 64'd0);
    drain(1);
    check("rel_in_tready", {63'd0, in_tready_a}, 64'd1);

    // Basic HDR=16 len=20
    clear_logs();
    send_pkt(1'b0, 16, 32'd20, 20, 0, 99);
    drain(6);
    check("t1_count", 64'(q_a.size()), 64'd3);
    chk_beat("t1_b0", 1'b0, 0, 64'h0706050403020100, 8'hFF, 1'b0, 32'd20);
    chk_beat("t1_b1", 1'b0, 1, 64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, 32'd20);
    chk_beat("t1_b2", 1'b0, 2, 64'h0000000013121110, 8'h0F, 1'b1, 32'd20);
    check("t1_errs", 64'(n_es_a + n_el_a), 64'd0);

    // HDR=14 len=10, second word comes from the residue flush
    clear_logs();
    send_pkt(1'b1, 14, 32'd10, 10, 0, 99);
    drain(6);
    check("t2_count", 64'(q_b.size()), 64'd2);
    chk_beat("t2_b0", 1'b1, 0, 64'h0706050403020100, 8'hFF, 1'b0, 32'd10);
    chk_beat("t2_b1", 1'b1, 1, 64'h0000000000000908, 8'h03, 1'b1, 32'd10);
    check("t2_errs", 64'(n_es_b + n_el_b), 64'd0);

    // Back-pressure with out_tready cycling 1,0,0,1
    clear_logs();
    @(negedge clk);
    rdy_idx   = 0;
    toggle_en = 1'b1;
    stall_chk = 1'b1;
    drain(1);
    send_pkt(1'b0, 16, 32'd20, 20, 0, 99);
    drain(20);
    stall_chk = 1'b0;
    toggle_en = 1'b0;
    drain(2);
    check("t3_count", 64'(q_a.size()), 64'd3);
    chk_beat("t3_b0", 1'b0, 0, 64'h0706050403020100, 8'hFF, 1'b0, 32'd20);
    chk_beat("t3_b1", 1'b0, 1, 64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, 32'd20);
    chk_beat("t3_b2", 1'b0, 2, 64'h0000000013121110, 8'h0F, 1'b1, 32'd20);
    check("t3_held_seen", {63'd0, n_held > 0}, 64'd1);
    check("t3_ready_while_held", 64'(n_viol), 64'd0);

    // len=32 but input ends after 8 payload bytes
    clear_logs();
    send_pkt(1'b0, 16, 32'd32, 8, 0, 99);
    drain(6);
    check("t4_count", 64'(q_a.size()), 64'd1);
    chk_beat("t4_b0", 1'b0, 0, 64'h0706050403020100, 8'hFF, 1'b1, 32'd32);
    check("t4_err_short", 64'(n_es_a), 64'd1);
    check("t4_err_long", 64'(n_el_a), 64'd0);

    // len=4 with two extra beats, then a normal len=8 packet
    clear_logs();
    send_pkt(1'b0, 16, 32'd4, 4, 2, 99);
    send_pkt(1'b0, 16, 32'd8, 8, 0, 99);
    drain(6);
    check("t5_count", 64'(q_a.size()), 64'd2);
    chk_beat("t5_b0", 1'b0, 0, 64'h0000000003020100, 8'h0F, 1'b1, 32'd4);
    chk_beat("t5_b1", 1'b0, 1, 64'h0706050403020100, 8'hFF, 1'b1, 32'd8);
    check("t5_err_long", 64'(n_el_a), 64'd1);
    check("t5_err_short", 64'(n_es_a), 64'd0);

    // len=0 drops silently; reset mid-payload of the next packet, then a fresh len=8
    clear_logs();
    send_pkt(1'b0, 16, 32'd0, 0, 1, 99);
    drain(6);
    check("t6_len0_count", 64'(q_a.size()), 64'd0);
    check("t6_len0_errs", 64'(n_es_a + n_el_a), 64'd0);
    send_pkt(1'b0, 16, 32'd20, 20, 0, 3);
    rst_n = 1'b0;
    drain(2);
    check("t6_rst_tvalid", {63'd0, out_tvalid_a}, 64'd0);
    rst_n = 1'b1;
    drain(2);
    clear_logs();
    send_pkt(1'b0, 16, 32'd8, 8, 0, 99);
    drain(6);
    check("t6_count", 64'(q_a.size()), 64'd1);
    chk_beat("t6_b0", 1'b0, 0, 64'h0706050403020100, 8'hFF, 1'b1, 32'd8);
    check("t6_errs", 64'(n_es_a + n_el_a), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pcap_axi4s_hdr_strip.md
# pcap_axi4s_hdr_strip

Synthesizable AXI4-Stream stage downstream of the pcap-to-AXI4-Stream packet source. Each input packet is a fixed-size record header followed by payload, packed little-endian (stream byte n in tdata[8n%W +: 8]), zero-padded in the last beat, with no tkeep. The block strips the header, extracts the 32-bit length field, realigns the payload to byte 0 of the output word, and emits it with tkeep and tlast derived from the length.

## Interface
- AXI_WIDTH, 64: data width in bits; power of two, at least 32. B = AXI_WIDTH/8.
- HDR_BYTES, 16: header bytes per packet; any value from 4 to 64.
- LEN_OFFSET, 8: byte offset of the little-endian 32-bit length field inside the header; LEN_OFFSET+4 <= HDR_BYTES.
- clk  in  1  clock; all logic is on posedge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- in_tdata  in  AXI_WIDTH  input data.
- in_tvalid  in  1  input valid.
- in_tlast  in  1  last input beat of the packet.
- in_tready  out  1  input ready.
- out_tdata  out  AXI_WIDTH  realigned payload; bytes with tkeep=0 are zero.
- out_tkeep  out  B  byte enables; contiguous from bit 0.
- out_tlast  out  1  last payload beat.
- out_tvalid  out  1  output valid.
- out_tready  in  1  output ready.
- out_len  out  32  length field of the current packet; valid whenever out_tvalid=1 and stable for the whole packet.
- err_short  out  1  one-cycle pulse: input tlast arrived before the header and length bytes were complete.
- err_long  out  1  one-cycle pulse: an input beat arrived after the packet's length bytes were complete.

## Operation
- S = HDR_BYTES mod B. HW = floor(HDR_BYTES/B).
- A residue register holds bytes S..B-1 of the previous input beat. Output word k is residue[B-S bytes] concatenated with bytes 0..S-1 of the next beat. When S=0, words pass through directly.
- States:
  - HDR: accept and capture header bytes.
  - BODY: accept beats and emit output words.
  - FLUSH: emit the final word from the residue only; in_tready=0.
  - DROP: accept and discard beats until in_tlast.
- HDR -> BODY on the beat that completes the header; remaining bytes of that beat are loaded into the residue.
- Length field len = 0: HDR -> DROP. If the completing beat has tlast, go to HDR instead. No output beat is produced.
- BODY -> FLUSH when the remaining payload fits in the residue (remaining <= B-S). Otherwise, emit the last word directly with out_tlast=1.
- After the last output word: go to HDR if the completing input beat had tlast. Otherwise go to DROP and pulse err_long on the first extra beat accepted.
- Early in_tlast in BODY: emit the received payload bytes as the final word with tlast, tkeep = received count, and pulse err_short. Go to HDR.
- Early in_tlast in HDR (truncated header): no output, pulse err_short, stay in HDR.
- Length arithmetic uses 32-bit unsigned counters. A byte counter is decremented by B per output word. tkeep for the final word is (1 << rem) - 1, where rem = 1..B.

## Timing
- Reset values: out_tvalid=0, out_tlast=0, out_tkeep=0, out_tdata=0, out_len=0, err_short=0, err_long=0, in_tready=0. State is HDR and the residue is cleared.
- in_tready=1 from the first clock after reset is released.
- Output is a registered stage with latency 1 cycle from the accepting input beat to out_tvalid.
- Handshake rules:
  - in_tready = !out_tvalid || out_tready in BODY.
  - in_tready = 1 in HDR and DROP.
  - in_tready = 0 in FLUSH.
- Output signals hold stable while out_tvalid && !out_tready (AXI4-Stream rule).
- Full throughput: one output word per cycle in steady state when out_tready=1.
- Reset asserted mid-packet: all state is discarded immediately. The next input beat after release is treated as a header start.

## Structure
- Package pcap_stream_pkg holds:
  - cdiv(a,b) function;
  - PCAP_REC_HDR_BYTES=16 and PCAP_INCL_LEN_OFFSET=8;
  - state enum hdr_strip_state_t {HDR, BODY, FLUSH, DROP};
  - keep_from_count(n, B) function.
- One sub-module: axi4s_reg_slice (AXI_WIDTH, with tkeep/tlast), a single-entry registered output stage that owns out_* and the ready back-pressure.

## Test plan
- AXI_WIDTH=64, HDR=16, len=20, payload 0x00..0x13 -> 3 output beats with tkeep 0xFF, 0xFF, 0x0F. tlast on beat 3, out_len=20, no error pulses.
- HDR=14, len=10 (3 input beats) -> beat 1 is payload 0x00..0x07 with tkeep 0xFF. Beat 2 comes via FLUSH with data 0x09_08 and tkeep 0x03.
- HDR=16, len=20, out_tready toggling 1,0,0,1 -> identical bytes and order, no beat lost or duplicated, in_tready low while output held.
- HDR=16, len=32 but input tlast at byte 24 -> final output beat tkeep 0xFF with tlast, one err_short pulse.
- HDR=16, len=4 with 2 extra padded beats -> one output beat with tkeep 0x0F, one err_long pulse, extra beats dropped, next packet correct.
- len=0, followed by rst_n asserted mid-payload of the next packet -> no output for the len=0 packet. After reset, a fresh len=8 packet gives one beat with tkeep 0xFF.
